// File: rtl/rfile_wb_ctrl.sv
// rfile_wb_ctrl: round-robin writeback arbiter for the register-file write port with a RAW busy scoreboard.
// Optional RFILE_WB_STATS_EN adds transfer and conflict counters.
module rfile_wb_ctrl #(
   parameter int REG_AW = 5,
   parameter int DAT_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_a_valid,
   input  logic [REG_AW-1:0] i_a_rd,
   input  logic [DAT_W-1:0]  i_a_dat,
   output logic              o_a_ready,
   input  logic              i_b_valid,
   input  logic [REG_AW-1:0] i_b_rd,
   input  logic [DAT_W-1:0]  i_b_dat,
   output logic              o_b_ready,
   input  logic              i_iss_valid,
   input  logic [REG_AW-1:0] i_iss_rd,
   input  logic [REG_AW-1:0] i_rs1_no,
   input  logic [REG_AW-1:0] i_rs2_no,
   output logic              o_rs1_busy,
   output logic              o_rs2_busy,
`ifdef RFILE_WB_STATS_EN
   output logic [31:0]       o_stat_a_cnt,
   output logic [31:0]       o_stat_b_cnt,
   output logic [31:0]       o_stat_conflict_cnt,
`endif
   output logic              o_rd_write,
   output logic [REG_AW-1:0] o_rd_no,
   output logic [DAT_W-1:0]  o_rd_dat
);
   localparam int NREG = 2 ** REG_AW;
   logic              last_b_q;
   logic              grant_a, grant_b, conflict, xfer;
   logic [REG_AW-1:0] wb_rd;
   logic [DAT_W-1:0]  wb_dat;
   logic [NREG-1:0]   busy_q, busy_d;
   logic              rd_write_q;
   logic [REG_AW-1:0] rd_no_q;
   logic [DAT_W-1:0]  rd_dat_q;
   assign conflict   = i_a_valid & i_b_valid;
   assign grant_a    = i_a_valid & (~i_b_valid | last_b_q);
   assign grant_b    = i_b_valid & (~i_a_valid | ~last_b_q);
   assign xfer       = grant_a | grant_b;
   assign wb_rd      = grant_a ? i_a_rd : i_b_rd;
   assign wb_dat     = grant_a ? i_a_dat : i_b_dat;
   assign o_a_ready  = grant_a;
   assign o_b_ready  = grant_b;
   assign o_rs1_busy = busy_q[i_rs1_no];
   assign o_rs2_busy = busy_q[i_rs2_no];
   assign o_rd_write = rd_write_q;
   assign o_rd_no    = rd_no_q;
   assign o_rd_dat   = rd_dat_q;
   // set is applied after clear so a newer issue to the same rd stays pending
   always_comb begin
      busy_d = busy_q;
      if (xfer) busy_d[wb_rd] = 1'b0;
      if (i_iss_valid) busy_d[i_iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_b_q   <= 1'b1;
         rd_write_q <= 1'b0;
         rd_no_q    <= '0;
         rd_dat_q   <= '0;
         busy_q     <= '0;
      end else begin
         if (conflict) last_b_q <= grant_b;
         rd_write_q <= xfer & (wb_rd != '0);
         if (xfer) begin
            rd_no_q  <= wb_rd;
            rd_dat_q <= wb_dat;
         end
         busy_q <= busy_d;
      end
   end
`ifdef RFILE_WB_STATS_EN
   logic [31:0] a_cnt_q, b_cnt_q, c_cnt_q;
   assign o_stat_a_cnt        = a_cnt_q;
   assign o_stat_b_cnt        = b_cnt_q;
   assign o_stat_conflict_cnt = c_cnt_q;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_cnt_q <= '0;
         b_cnt_q <= '0;
         c_cnt_q <= '0;
      end else begin
         if (grant_a) a_cnt_q <= a_cnt_q + 32'd1;
         if (grant_b) b_cnt_q <= b_cnt_q + 32'd1;
         if (conflict) c_cnt_q <= c_cnt_q + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_rfile_wb_ctrl.sv
// tb_rfile_wb_ctrl: directed vectors for rfile_wb_ctrl arbitration, write latency, scoreboard, x0 and async reset.
module tb_rfile_wb_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid, b_valid, iss_valid;
   logic [4:0]  a_rd, b_rd, iss_rd, rs1_no, rs2_no;
   logic [31:0] a_dat, b_dat;
   logic        a_ready, b_ready, rs1_busy, rs2_busy, rd_write;
   logic [4:0]  rd_no;
   logic [31:0] rd_dat;
`ifdef RFILE_WB_STATS_EN
   logic [31:0] st_a, st_b, st_c;
`endif
   int n_vec = 0;
   int n_err = 0;

   rfile_wb_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_a_valid(a_valid), .i_a_rd(a_rd), .i_a_dat(a_dat), .o_a_ready(a_ready),
      .i_b_valid(b_valid), .i_b_rd(b_rd), .i_b_dat(b_dat), .o_b_ready(b_ready),
      .i_iss_valid(iss_valid), .i_iss_rd(iss_rd),
      .i_rs1_no(rs1_no), .i_rs2_no(rs2_no),
      .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
`ifdef RFILE_WB_STATS_EN
      .o_stat_a_cnt(st_a), .o_stat_b_cnt(st_b), .o_stat_conflict_cnt(st_c),
`endif
      .o_rd_write(rd_write), .o_rd_no(rd_no), .o_rd_dat(rd_dat)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; a_valid = 0; b_valid = 0; iss_valid = 0;
      a_rd = 0; b_rd = 0; iss_rd = 0; rs1_no = 0; rs2_no = 0; a_dat = 0; b_dat = 0;
      #12;
      chk("rst_write", rd_write, 0);
      chk("rst_no", rd_no, 0);
      chk("rst_dat", rd_dat, 0);
      chk("rst_busy", rs1_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      // A only
      a_valid = 1; a_rd = 5; a_dat = 32'hDEADBEEF;
      #1;
      chk("a_only_ready", a_ready, 1);
      chk("a_only_bready", b_ready, 0);
      step(); a_valid = 0; #1;
      chk("a_only_wr", rd_write, 1);
      chk("a_only_no", rd_no, 5);
      chk("a_only_dat", rd_dat, 32'hDEADBEEF);
      step();
      chk("a_only_wr_off", rd_write, 0);
      chk("a_only_no_hold", rd_no, 5);
      chk("a_only_dat_hold", rd_dat, 32'hDEADBEEF);
      // first conflict: A wins
      a_valid = 1; a_rd = 3; a_dat = 32'h11; b_valid = 1; b_rd = 4; b_dat = 32'h22;
      #1;
      chk("cf1_aready", a_ready, 1);
      chk("cf1_bready", b_ready, 0);
      step(); a_valid = 0; #1;
      chk("cf1_wr", rd_write, 1);
      chk("cf1_no", rd_no, 3);
      chk("cf1_dat", rd_dat, 32'h11);
      chk("cf1_bready2", b_ready, 1);
      step(); b_valid = 0; #1;
      chk("cf1_no_b", rd_no, 4);
      chk("cf1_dat_b", rd_dat, 32'h22);
      // second conflict: B wins
      a_valid = 1; a_rd = 6; a_dat = 32'h66; b_valid = 1; b_rd = 7; b_dat = 32'h77;
      #1;
      chk("cf2_aready", a_ready, 0);
      chk("cf2_bready", b_ready, 1);
      step(); b_valid = 0; #1;
      chk("cf2_no_b", rd_no, 7);
      chk("cf2_dat_b", rd_dat, 32'h77);
      chk("cf2_aready2", a_ready, 1);
      step(); a_valid = 0; #1;
      chk("cf2_no_a", rd_no, 6);
      chk("cf2_dat_a", rd_dat, 32'h66);
      step();
      chk("cf2_wr_off", rd_write, 0);
      // scoreboard
      iss_valid = 1; iss_rd = 9; rs1_no = 9; rs2_no = 10;
      #1;
      chk("sb_pre", rs1_busy, 0);
      step(); iss_valid = 0; #1;
      chk("sb_set", rs1_busy, 1);
      chk("sb_other", rs2_busy, 0);
      step();
      chk("sb_hold", rs1_busy, 1);
      b_valid = 1; b_rd = 9; b_dat = 32'h99;
      #1;
      chk("sb_nofwd", rs1_busy, 1);
      step(); b_valid = 0; #1;
      chk("sb_wr", rd_write, 1);
      chk("sb_wr_no", rd_no, 9);
      chk("sb_clr", rs1_busy, 0);
      iss_valid = 1; iss_rd = 9;
      step(); #1;
      b_valid = 1; b_rd = 9; b_dat = 32'h9A;
      step(); iss_valid = 0; b_valid = 0; #1;
      chk("sb_same_wr", rd_write, 1);
      chk("sb_same_busy", rs1_busy, 1);
      b_valid = 1;
      step(); b_valid = 0; #1;
      chk("sb_clr2", rs1_busy, 0);
      iss_valid = 1; iss_rd = 10;
      step(); iss_valid = 0; #1;
      chk("sb_rs2", rs2_busy, 1);
      chk("sb_rs1_idle", rs1_busy, 0);
      // x0
      a_valid = 1; a_rd = 0; a_dat = 32'hFFFFFFFF;
      #1;
      chk("x0_ready", a_ready, 1);
      step(); a_valid = 0; #1;
      chk("x0_wr", rd_write, 0);
      iss_valid = 1; iss_rd = 0; rs1_no = 0;
      step(); iss_valid = 0; #1;
      chk("x0_busy", rs1_busy, 0);
      // async reset mid-operation
      iss_valid = 1; iss_rd = 12; rs1_no = 12;
      step(); iss_valid = 0; #1;
      a_valid = 1; a_rd = 13; a_dat = 32'h13;
      step(); a_valid = 0; #1;
      chk("ar_pre_busy", rs1_busy, 1);
      chk("ar_pre_wr", rd_write, 1);
      rst_n = 1'b0;
      #1;
      chk("ar_busy", rs1_busy, 0);
      chk("ar_wr", rd_write, 0);
      chk("ar_no", rd_no, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("ar_after_busy", rs1_busy, 0);
      chk("ar_after_rs2", rs2_busy, 0);
`ifdef RFILE_WB_STATS_EN
      rst_n = 1'b0; #1;
      chk("st_rst", st_a | st_b | st_c, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      a_valid = 1; b_valid = 1; a_rd = 0; b_rd = 0;
      step(); step(); step();
      b_valid = 0;
      step(); step();
      a_valid = 0; #1;
      chk("st_conflict", st_c, 3);
      chk("st_a", st_a, 4);
      chk("st_b", st_b, 1);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
